sbqm_sensor_conditioner: RTL and testbench
==========================================

Name: sbqm_sensor_conditioner

Overview:
Clocked front end for the bank queue manager. It takes the raw entry and exit photocell beams, synchronises and debounces them, and tracks each beam with a small FSM. It emits clean single-cycle EnterPulse/LeavePulse events that drive the queue counter's SenseIn/SenseOut path. It also resolves simultaneous enter/leave, rejects entries while the queue is full, and flags a beam held blocked too long.

Parameters:
SYNC_STAGES, 2, synchroniser flops per raw beam input (legal values 2..4)
DEBOUNCE_CYCLES, 16, consecutive identical synchronised samples needed to accept a beam level change (legal values >=2)
STUCK_CYCLES, 1000, cycles a beam may stay blocked before StuckFlag asserts (legal values > DEBOUNCE_CYCLES)

Ports:
Clk  input  1  system clock, all state on rising edge
Reset  input  1  asynchronous, active-high reset
BeamInRaw  input  1  entry photocell, async; 1 = clear, 0 = blocked
BeamOutRaw  input  1  exit photocell, async; 1 = clear, 0 = blocked
FullIn  input  1  FullFlag fed back from the queue counter
EmptyIn  input  1  EmptyFlag fed back from the queue counter
EnterPulse  output  1  one-cycle pulse: customer entered, count +1
LeavePulse  output  1  one-cycle pulse: customer left, count -1
SimulPulse  output  1  one-cycle pulse: entry and exit completed in the same cycle, net change 0
RejectPulse  output  1  one-cycle pulse: entry completed while FullIn=1, or exit completed while EmptyIn=1
StuckFlag  output  2  [0] entry beam stuck, [1] exit beam stuck; level outputs

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-high. All flops clear immediately on Reset=1.
- Reset values:
  - Synchroniser flops and debounced levels reset to 1 (clear).
  - Both FSMs reset to CLEAR; all counters reset to 0.
  - All pulse outputs reset to 0; StuckFlag resets to 2'b00.
  - Reset mid-operation abandons any partial event; no pulse is emitted as a result of reset.
- Synchroniser: a SYNC_STAGES flop chain per beam.
- Debounce, per channel:
  - Counter increments while the synchronised sample differs from the debounced level; it clears to 0 on any matching sample.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a differing sample, the debounced level toggles and the counter clears.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Channel FSM, per beam. States: CLEAR, BLOCKED, STUCK.
  - CLEAR -> BLOCKED on debounced 1->0. The dwell counter clears to 0.
  - BLOCKED: the dwell counter increments each cycle and saturates at STUCK_CYCLES. When it reaches STUCK_CYCLES-1, go to STUCK.
  - STUCK: the corresponding StuckFlag bit is 1.
  - BLOCKED or STUCK -> CLEAR on debounced 0->1. This raises the channel's internal done strobe for one cycle and clears the StuckFlag bit in the same cycle.
  - A long blockage produces exactly one event.
- Latency: one clean raw 1->0->1 sequence produces a done strobe, registered to the outputs, in the cycle SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks after the first Clk edge that samples the raw 0->1 transition.
- Event arbitration, registered and evaluated on the done strobes:
  - Entry done only: EnterPulse=1 if FullIn=0, else RejectPulse=1.
  - Exit done only: LeavePulse=1 if EmptyIn=0, else RejectPulse=1.
  - Both done in the same cycle: SimulPulse=1, EnterPulse=LeavePulse=0. This holds even if FullIn or EmptyIn is set, because occupancy is unchanged.
- Output rules:
  - EnterPulse and LeavePulse are never high in the same cycle.
  - Each pulse output is high for exactly one cycle per qualifying event.
- Glitches shorter than DEBOUNCE_CYCLES produce no state change and no pulse.

Decomposition:
- Package sbqm_pkg holds:
  - the channel state enum (CLEAR, BLOCKED, STUCK);
  - the beam level constants BEAM_CLEAR=1 and BEAM_BLOCKED=0;
  - the StuckFlag bit indices STUCK_IN=0 and STUCK_OUT=1.
- One sub-module, sbqm_beam_channel, contains the synchroniser, the debounce counter, the FSM and the dwell counter, and outputs done and stuck. The top instantiates it twice and holds only the arbitration register stage.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, STUCK_CYCLES=20.
- Clean entry: BeamInRaw held 0 for 10 cycles, then held 1. Required: exactly one EnterPulse, 7 cycles after the sampled rise; no other pulse.
- Glitch: BeamOutRaw 0 for 2 cycles, then held 1. Required: no pulse; FSM stays in CLEAR.
- Simultaneous: both beams blocked for 10 cycles, then released on the same edge. Required: one SimulPulse; EnterPulse and LeavePulse stay 0.
- Full reject: FullIn=1, clean entry. Required: RejectPulse=1 for 1 cycle; EnterPulse=0.
- Empty reject: EmptyIn=1, clean exit. Required: RejectPulse=1 for 1 cycle; LeavePulse=0.
- Stuck: BeamInRaw held 0 for 40 cycles. Required: StuckFlag[0] rises and stays 1 until release. On release it clears in the same cycle that a single EnterPulse fires.
- Reset mid-blockage: Reset asserted while BeamOutRaw=0 in BLOCKED. Required: all outputs are 0 immediately. After Reset is released, a release with no fresh blockage produces no LeavePulse.

Source files
------------

// File: rtl/sbqm_pkg.sv
// Shared types and constants for the bank queue manager sensor front end.
package sbqm_pkg;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    BLOCKED = 2'd1,
    STUCK   = 2'd2
  } chan_state_e;

  localparam logic BEAM_CLEAR   = 1'b1;
  localparam logic BEAM_BLOCKED = 1'b0;

  localparam int STUCK_IN  = 0;
  localparam int STUCK_OUT = 1;

endpackage

// File: rtl/sbqm_beam_channel.sv
// One photocell channel: synchroniser, debounce filter, CLEAR/BLOCKED/STUCK
// tracker and dwell counter. Emits a one-cycle done strobe on beam release.
module sbqm_beam_channel
  import sbqm_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        beam_raw_i,
  output logic        done_o,
  output logic        stuck_o,
  output chan_state_e state_o
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int DW_W = $clog2(STUCK_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(STUCK_CYCLES - 1);
  localparam logic [DW_W-1:0] DWELL_MAX  = DW_W'(STUCK_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  chan_state_e            state_q, state_d;
  logic [DW_W-1:0]        dwell_q, dwell_d;
  logic                   done_q, done_d;

  assign sample = sync_q[SYNC_STAGES-1];

  // Level only flips after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (sample != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = sample;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    case (state_q)
      CLEAR: begin
        if (level_q == BEAM_BLOCKED) begin
          state_d = BLOCKED;
          dwell_d = '0;
        end
      end
      BLOCKED, STUCK: begin
        if (level_q == BEAM_CLEAR) begin
          state_d = CLEAR;
          done_d  = 1'b1;
        end else begin
          if (state_q == BLOCKED && dwell_q == DWELL_LAST) begin
            state_d = STUCK;
          end
          if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= {SYNC_STAGES{BEAM_CLEAR}};
      db_cnt_q <= '0;
      level_q  <= BEAM_CLEAR;
      state_q  <= CLEAR;
      dwell_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], beam_raw_i};
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      done_q   <= done_d;
    end
  end

  assign done_o  = done_q;
  assign stuck_o = (state_q == STUCK);
  assign state_o = state_q;

endmodule

// File: rtl/sbqm_sensor_conditioner.sv
// Entry/exit beam conditioner: two debounced channels feeding a registered
// arbitration stage that turns release strobes into queue-counter events.
module sbqm_sensor_conditioner
  import sbqm_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES    = 1000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BeamInRaw,
  input  logic       BeamOutRaw,
  input  logic       FullIn,
  input  logic       EmptyIn,
  output logic       EnterPulse,
  output logic       LeavePulse,
  output logic       SimulPulse,
  output logic       RejectPulse,
  output logic [1:0] StuckFlag
);

  logic        in_done, out_done;
  logic        in_stuck, out_stuck;
  chan_state_e in_state, out_state;

  logic       enter_q, enter_d;
  logic       leave_q, leave_d;
  logic       simul_q, simul_d;
  logic       reject_q, reject_d;
  logic [1:0] stuck_q, stuck_d;

  sbqm_beam_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_in (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .beam_raw_i(BeamInRaw),
    .done_o    (in_done),
    .stuck_o   (in_stuck),
    .state_o   (in_state)
  );

  sbqm_beam_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_out (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .beam_raw_i(BeamOutRaw),
    .done_o    (out_done),
    .stuck_o   (out_stuck),
    .state_o   (out_state)
  );

  // A same-cycle entry and exit leaves occupancy unchanged, so full/empty
  // only gate single-sided events.
  always_comb begin
    enter_d  = in_done & ~out_done & ~FullIn;
    leave_d  = out_done & ~in_done & ~EmptyIn;
    simul_d  = in_done & out_done;
    reject_d = (in_done & ~out_done & FullIn) | (out_done & ~in_done & EmptyIn);
    stuck_d            = '0;
    stuck_d[STUCK_IN]  = in_stuck;
    stuck_d[STUCK_OUT] = out_stuck;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      enter_q  <= 1'b0;
      leave_q  <= 1'b0;
      simul_q  <= 1'b0;
      reject_q <= 1'b0;
      stuck_q  <= 2'b00;
    end else begin
      enter_q  <= enter_d;
      leave_q  <= leave_d;
      simul_q  <= simul_d;
      reject_q <= reject_d;
      stuck_q  <= stuck_d;
    end
  end

  // A release strobe always coincides with the channel having returned to CLEAR.
  a_in_done_clear: assert property (@(posedge Clk) disable iff (Reset)
    !in_done || in_state == CLEAR);
  a_out_done_clear: assert property (@(posedge Clk) disable iff (Reset)
    !out_done || out_state == CLEAR);

  assign EnterPulse  = enter_q;
  assign LeavePulse  = leave_q;
  assign SimulPulse  = simul_q;
  assign RejectPulse = reject_q;
  assign StuckFlag   = stuck_q;

endmodule

// File: tb/tb_sbqm_sensor_conditioner.sv
// Directed bench for sbqm_sensor_conditioner with a cycle-stamped pulse scoreboard.
module tb_sbqm_sensor_conditioner;
  import sbqm_pkg::*;

  localparam int W = 20;  // {cycle[15:0], simul, reject, leave, enter}

  logic       Clk;
  logic       Reset;
  logic       BeamInRaw;
  logic       BeamOutRaw;
  logic       FullIn;
  logic       EmptyIn;
  logic       EnterPulse;
  logic       LeavePulse;
  logic       SimulPulse;
  logic       RejectPulse;
  logic [1:0] StuckFlag;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int d0    = 0;
  int r0    = 0;

  sbqm_sensor_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .STUCK_CYCLES   (20)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .BeamInRaw  (BeamInRaw),
    .BeamOutRaw (BeamOutRaw),
    .FullIn     (FullIn),
    .EmptyIn    (EmptyIn),
    .EnterPulse (EnterPulse),
    .LeavePulse (LeavePulse),
    .SimulPulse (SimulPulse),
    .RejectPulse(RejectPulse),
    .StuckFlag  (StuckFlag)
  );

  // Clock and cycle stamp: cyc equals the number of rising edges seen so far.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic expect_at(input int at, input logic [3:0] pulses);
    exp_q.push_back({16'(at), pulses});
  endtask

  // Raw rise driven now is sampled on edge cyc+1; pulse registers 7 edges later.
  task automatic beam_event(input bit use_in, input bit use_out, input int low_cycles,
                            input bit want_pulse, input logic [3:0] pulses);
    if (use_in)  BeamInRaw  = 1'b0;
    if (use_out) BeamOutRaw = 1'b0;
    step(low_cycles);
    if (use_in)  BeamInRaw  = 1'b1;
    if (use_out) BeamOutRaw = 1'b1;
    if (want_pulse) expect_at(cyc + 8, pulses);
    step(16);
  endtask

  // Monitor: any pulse output must match the head of the expected queue.
  always @(negedge Clk) begin
    logic [3:0]   p;
    logic [W-1:0] got;
    logic [W-1:0] want;
    p = {SimulPulse, RejectPulse, LeavePulse, EnterPulse};
    if (!Reset && p != 4'b0000) begin
      got = {16'(cyc), p};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got cyc=%0d pulses=%b want none", cyc, p);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL pulse: got cyc=%0d pulses=%b want cyc=%0d pulses=%b",
                   cyc, p, want[W-1:4], want[3:0]);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1; BeamInRaw = 1'b1; BeamOutRaw = 1'b1; FullIn = 1'b0; EmptyIn = 1'b0;
    step(3);
    check("reset_pulses", {28'd0, SimulPulse, RejectPulse, LeavePulse, EnterPulse}, 0);
    check("reset_stuck", StuckFlag, 2'b00);
    Reset = 1'b0;
    step(2);
    check("idle_in_state", dut.u_in.state_o, CLEAR);
    check("idle_out_state", dut.u_out.state_o, CLEAR);

    // Clean entry
    beam_event(1, 0, 10, 1, 4'b0001);

    // Glitch on exit beam shorter than the debounce window
    BeamOutRaw = 1'b0;
    step(2);
    BeamOutRaw = 1'b1;
    step(6);
    check("glitch_state", dut.u_out.state_o, CLEAR);
    step(10);

    // Clean exit
    beam_event(0, 1, 10, 1, 4'b0010);

    // Simultaneous release, plain and with both occupancy flags set
    beam_event(1, 1, 10, 1, 4'b1000);
    FullIn = 1'b1; EmptyIn = 1'b1;
    beam_event(1, 1, 10, 1, 4'b1000);
    FullIn = 1'b0; EmptyIn = 1'b0;

    // Entry while full, exit while empty
    FullIn = 1'b1;
    beam_event(1, 0, 10, 1, 4'b0100);
    FullIn = 1'b0;
    EmptyIn = 1'b1;
    beam_event(0, 1, 10, 1, 4'b0100);
    EmptyIn = 1'b0;

    // Stuck entry beam: STUCK after edge d0+27, flag registered at d0+28
    d0 = cyc;
    BeamInRaw = 1'b0;
    step(27);
    check("stuck_not_yet", StuckFlag, 2'b00);
    step(1);
    check("stuck_rise", StuckFlag, 2'b01);
    check("stuck_state", dut.u_in.state_o, STUCK);
    step(d0 + 40 - cyc);
    check("stuck_hold", StuckFlag, 2'b01);
    BeamInRaw = 1'b1;
    r0 = cyc;
    expect_at(r0 + 8, 4'b0001);
    step(7);
    check("stuck_before_release", StuckFlag, 2'b01);
    step(1);
    check("stuck_cleared_with_enter", StuckFlag, 2'b00);
    step(10);

    // Reset while the exit beam is stuck, then release during reset
    BeamOutRaw = 1'b0;
    step(30);
    check("out_stuck_flag", StuckFlag, 2'b10);
    #1 Reset = 1'b1;
    #1;
    check("async_reset_stuck", StuckFlag, 2'b00);
    check("async_reset_pulses", {28'd0, SimulPulse, RejectPulse, LeavePulse, EnterPulse}, 0);
    BeamOutRaw = 1'b1;
    step(3);
    Reset = 1'b0;
    step(20);
    check("post_reset_state", dut.u_out.state_o, CLEAR);
    check("post_reset_stuck", StuckFlag, 2'b00);

    step(5);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
